// File: rtl/axil_lsu_if.sv
// Core-request/response and AXI4-Lite bus signals of axil_lsu, grouped in one bundle.
// AXIL_LSU_RESP_ERR_EN adds the bresp/rresp response fields.
interface axil_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_fetch;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_misalign;
    logic                  rsp_err;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
`ifdef AXIL_LSU_RESP_ERR_EN
    logic [1:0]            bresp;
    logic [1:0]            rresp;
`endif

    // LSU side: serves the core, masters the AXI bus
    modport master (
        input  req_valid, req_we, req_fetch, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_err,
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, output rready
`ifdef AXIL_LSU_RESP_ERR_EN
        , input bresp, rresp
`endif
    );

    // Environment side: the core plus the AXI slave
    modport slave (
        output req_valid, req_we, req_fetch, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_err,
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, input rready
`ifdef AXIL_LSU_RESP_ERR_EN
        , output bresp, rresp
`endif
    );
endinterface

// File: rtl/axil_lsu.sv
// axil_lsu: one-request-at-a-time AXI4-Lite load/store/fetch unit with lane steering.
// Define AXIL_LSU_RESP_ERR_EN to report bresp/rresp errors on rsp_err.
module axil_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    axil_lsu_if.master io_bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int L      = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_D, S_WR_AW_W, S_WR_W, S_WR_AW, S_WR_B, S_RESP, S_ERR
    } state_t;

    state_t r_state, w_state_next;

    logic [L-1:0]      w_off;
    logic [L-1:0]      w_align_mask;
    logic              w_illegal;
    logic              w_bad;
    logic              w_accept;
    logic [3:0]        w_nbytes;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] w_wdata;

    logic [6:0]        w_nbits;
    logic [DATA_W-1:0] w_keep;
    logic [DATA_W-1:0] w_shift;
    logic              w_sign;
    logic [DATA_W-1:0] w_load;

    logic [1:0]        r_size;
    logic              r_signed;
    logic [L-1:0]      r_off;
    logic              r_req_ready;
    logic              r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic [ADDR_W-1:0] r_araddr, r_awaddr;
    logic [2:0]        r_arprot;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_rsp_valid, r_rsp_misalign;
    logic [DATA_W-1:0] r_rsp_rdata;

    assign w_off    = io_bus.req_addr[L-1:0];
    assign w_accept = (r_state == S_IDLE) && io_bus.req_valid;

    // Alignment: the low log2(bytes) offset bits must be zero; dword needs a 64-bit bus
    always_comb begin
        w_align_mask = '0;
        w_illegal    = 1'b0;
        case (io_bus.req_size)
            2'b00:   w_align_mask = '0;
            2'b01:   w_align_mask = L'(1);
            2'b10:   w_align_mask = L'(3);
            default: begin
                w_align_mask = L'(7);
                w_illegal    = (DATA_W == 32);
            end
        endcase
    end
    assign w_bad = w_illegal || ((w_off & w_align_mask) != '0);

    always_comb begin
        w_nbytes = 4'd1 << io_bus.req_size;
        w_strb   = (~({STRB_W{1'b1}} << w_nbytes)) << w_off;
        case (io_bus.req_size)
            2'b00:   w_wdata = {STRB_W{io_bus.req_wdata[7:0]}};
            2'b01:   w_wdata = {(DATA_W/16){io_bus.req_wdata[15:0]}};
            2'b10:   w_wdata = {(DATA_W/32){io_bus.req_wdata[31:0]}};
            default: w_wdata = io_bus.req_wdata;
        endcase
    end

    // Load steering: shift the addressed lanes down, keep 8*2^size bits, extend the rest
    always_comb begin
        w_nbits = 7'd8 << r_size;
        w_keep  = ~({DATA_W{1'b1}} << w_nbits);
        w_shift = io_bus.rdata >> {r_off, 3'b000};
        w_sign  = r_signed & w_shift[IDX_W'(w_nbits - 7'd1)];
        w_load  = (w_shift & w_keep) | ({DATA_W{w_sign}} & ~w_keep);
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.req_valid) begin
                    if (w_bad)              w_state_next = S_ERR;
                    else if (io_bus.req_we) w_state_next = S_WR_AW_W;
                    else                    w_state_next = S_RD_A;
                end
            end
            S_RD_A:  if (io_bus.arready) w_state_next = S_RD_D;
            S_RD_D:  if (io_bus.rvalid)  w_state_next = S_RESP;
            S_WR_AW_W: begin
                if (io_bus.awready && io_bus.wready) w_state_next = S_WR_B;
                else if (io_bus.awready)             w_state_next = S_WR_W;
                else if (io_bus.wready)              w_state_next = S_WR_AW;
            end
            S_WR_W:  if (io_bus.wready)  w_state_next = S_WR_B;
            S_WR_AW: if (io_bus.awready) w_state_next = S_WR_B;
            S_WR_B:  if (io_bus.bvalid)  w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the state being entered
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_req_ready    <= 1'b1;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_misalign <= 1'b0;
        end else begin
            r_req_ready    <= (w_state_next == S_IDLE);
            r_arvalid      <= (w_state_next == S_RD_A);
            r_rready       <= (w_state_next == S_RD_D);
            r_awvalid      <= (w_state_next == S_WR_AW_W) || (w_state_next == S_WR_AW);
            r_wvalid       <= (w_state_next == S_WR_AW_W) || (w_state_next == S_WR_W);
            r_bready       <= (w_state_next == S_WR_B);
            r_rsp_valid    <= (w_state_next == S_RESP) || (w_state_next == S_ERR);
            r_rsp_misalign <= (w_state_next == S_ERR);
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_size   <= '0;
            r_signed <= 1'b0;
            r_off    <= '0;
            r_araddr <= '0;
            r_arprot <= '0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_accept && !w_bad) begin
            r_size   <= io_bus.req_size;
            r_signed <= io_bus.req_signed;
            r_off    <= w_off;
            if (io_bus.req_we) begin
                r_awaddr <= io_bus.req_addr;
                r_wdata  <= w_wdata;
                r_wstrb  <= w_strb;
            end else begin
                r_araddr <= io_bus.req_addr;
                r_arprot <= {io_bus.req_fetch, 2'b00};
            end
        end
    end

`ifdef AXIL_LSU_RESP_ERR_EN
    logic r_rsp_err;
    logic w_unused;
    assign w_unused       = io_bus.rresp[0] ^ io_bus.bresp[0];
    assign io_bus.rsp_err = r_rsp_err;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_state_next == S_IDLE) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == S_RD_D && io_bus.rvalid) begin
            r_rsp_rdata <= io_bus.rresp[1] ? '0 : w_load;
            r_rsp_err   <= io_bus.rresp[1];
        end else if (r_state == S_WR_B && io_bus.bvalid) begin
            r_rsp_err   <= io_bus.bresp[1];
        end
    end
`else
    assign io_bus.rsp_err = 1'b0;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rsp_rdata <= '0;
        end else if (w_state_next == S_IDLE) begin
            r_rsp_rdata <= '0;
        end else if (r_state == S_RD_D && io_bus.rvalid) begin
            r_rsp_rdata <= w_load;
        end
    end
`endif

    assign io_bus.req_ready    = r_req_ready;
    assign io_bus.rsp_valid    = r_rsp_valid;
    assign io_bus.rsp_rdata    = r_rsp_rdata;
    assign io_bus.rsp_misalign = r_rsp_misalign;
    assign io_bus.arvalid      = r_arvalid;
    assign io_bus.araddr       = r_araddr;
    assign io_bus.arprot       = r_arprot;
    assign io_bus.rready       = r_rready;
    assign io_bus.awvalid      = r_awvalid;
    assign io_bus.awaddr       = r_awaddr;
    assign io_bus.awprot       = 3'b000;
    assign io_bus.wvalid       = r_wvalid;
    assign io_bus.wdata        = r_wdata;
    assign io_bus.wstrb        = r_wstrb;
    assign io_bus.bready       = r_bready;
endmodule
